// File: rtl/deparser_pkg.sv
// Shared constants for the deparser: PHV field map, deparse action word layout and FSM encodings.
package deparser_pkg;

    localparam int HDR_SEGS  = 4;
    localparam int HDR_BYTES = 128;

    localparam int C6B_BASE = 740;
    localparam int C4B_BASE = 484;
    localparam int C2B_BASE = 356;

    localparam int VLAN_LSB  = 129;
    localparam int VLAN_MSB  = 140;
    localparam int DROP_BIT  = 128;
    localparam int TUSER_MSB = 127;

    localparam int ACT_W         = 16;
    localparam int ACT_NUM       = 10;
    localparam int ACT_VALID_BIT = 0;
    localparam int ACT_TYPE_LSB  = 1;
    localparam int ACT_IDX_LSB   = 3;
    localparam int ACT_OFF_LSB   = 6;

    localparam logic [1:0] TYPE_SKIP = 2'b00;
    localparam logic [1:0] TYPE_2B   = 2'b01;
    localparam logic [1:0] TYPE_4B   = 2'b10;
    localparam logic [1:0] TYPE_6B   = 2'b11;

    typedef struct packed {
        logic [2:0] rsvd;
        logic [6:0] off;
        logic [2:0] idx;
        logic [1:0] typ;
        logic       vld;
    } act_t;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE        = 3'd0;
    localparam state_t ST_HDR_COLLECT = 3'd1;
    localparam state_t ST_WAIT_PHV    = 3'd2;
    localparam state_t ST_RAM_RD      = 3'd3;
    localparam state_t ST_APPLY       = 3'd4;
    localparam state_t ST_EMIT_HDR    = 3'd5;
    localparam state_t ST_PASS_BODY   = 3'd6;

    // Action 0 sits in the most significant slot of the RAM word.
    function automatic act_t get_action(input logic [ACT_NUM*ACT_W-1:0] word, input int i);
        return act_t'(word[ACT_NUM*ACT_W - ACT_W*(i+1) +: ACT_W]);
    endfunction

endpackage

// File: rtl/deparser_act_ram.sv
// Deparse action table: 16 x 160 simple dual-port RAM, registered read returning pre-write data.
module deparse_act_ram
    import deparser_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = ACT_NUM*ACT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic              rd_vld_q;
    logic [DEPTH-1:0]  vld_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        rd_q <= mem[rd_addr_i];
    end

    // Per-entry written flags make an unwritten or reset entry read as all-skip.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_vld
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    vld_q[gi] <= 1'b0;
                end else if (wr_en_i && (wr_addr_i == ADDR_W'(gi))) begin
                    vld_q[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= vld_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_vld_q ? rd_q : '0;

endmodule

// File: rtl/deparser.sv
// Deparser: buffers the 128-byte header window, writes PHV containers back per VLAN action entry, re-emits on AXIS.
// Optional feature macro: DEPARSER_DROP_EN (PHV bit 128 drops the packet).
module deparser
    import deparser_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int PKT_HDR_LEN          = 1124
) (
    input  logic                              axis_clk,
    input  logic                              areset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    input  logic [PKT_HDR_LEN-1:0]            phv_in,
    input  logic                              phv_valid,
    output logic                              phv_ready,
    input  logic                              act_wr_en,
    input  logic [3:0]                        act_wr_addr,
    input  logic [ACT_NUM*ACT_W-1:0]          act_wr_data,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready
);

    localparam int DW       = C_S_AXIS_DATA_WIDTH;
    localparam int KW       = C_S_AXIS_DATA_WIDTH/8;
    localparam int HDR_BITS = HDR_SEGS*DW;

    state_t                          state_q, state_d;
    logic [HDR_SEGS-1:0][DW-1:0]     hdr_q;
    logic [HDR_SEGS-1:0][KW-1:0]     keep_q;
    logic [HDR_SEGS-1:0]             last_q;
    logic [2:0]                      seg_cnt_q;
    logic [1:0]                      emit_idx_q;
    logic [PKT_HDR_LEN-1:0]          phv_q;
    logic [ACT_NUM*ACT_W-1:0]        act_rd_data;
    logic                            drop;
    logic                            emit_adv;
    logic                            emit_last;

`ifdef DEPARSER_DROP_EN
    assign drop = phv_q[DROP_BIT];
    logic unused_ok;
    assign unused_ok = ^{s_axis_tuser, phv_q[C2B_BASE-1:VLAN_MSB+1],
                         phv_q[VLAN_MSB:VLAN_LSB+8], phv_q[VLAN_LSB+3:VLAN_LSB]};
`else
    assign drop = 1'b0;
    logic unused_ok;
    assign unused_ok = ^{s_axis_tuser, phv_q[C2B_BASE-1:VLAN_MSB+1],
                         phv_q[VLAN_MSB:VLAN_LSB+8], phv_q[VLAN_LSB+3:VLAN_LSB], phv_q[DROP_BIT]};
`endif

    deparse_act_ram u_act_ram (
        .clk_i     (axis_clk),
        .rst_i     (areset),
        .wr_en_i   (act_wr_en),
        .wr_addr_i (act_wr_addr),
        .wr_data_i (act_wr_data),
        .rd_addr_i (phv_q[VLAN_LSB+7:VLAN_LSB+4]),
        .rd_data_o (act_rd_data)
    );

    // Later actions overwrite earlier ones; container bytes landing past the window are dropped.
    function automatic logic [HDR_BITS-1:0] apply_actions(
        input logic [HDR_BITS-1:0]        hdr,
        input logic [ACT_NUM*ACT_W-1:0]   word,
        input logic [PKT_HDR_LEN-1:0]     phv
    );
        logic [HDR_BITS-1:0] res;
        act_t                a;
        logic [47:0]         val;
        int                  nbytes;
        int                  pos;
        res = hdr;
        for (int i = 0; i < ACT_NUM; i++) begin
            a      = get_action(word, i);
            nbytes = 0;
            val    = '0;
            if (a.vld) begin
                case (a.typ)
                    TYPE_2B: begin nbytes = 2; val = {32'b0, phv[C2B_BASE + 16*a.idx +: 16]}; end
                    TYPE_4B: begin nbytes = 4; val = {16'b0, phv[C4B_BASE + 32*a.idx +: 32]}; end
                    TYPE_6B: begin nbytes = 6; val = phv[C6B_BASE + 48*a.idx +: 48]; end
                    default: ;
                endcase
            end
            for (int j = 0; j < 6; j++) begin
                pos = int'(a.off) + j;
                if (j < nbytes && pos < HDR_BYTES) begin
                    res[8*pos +: 8] = val[8*(nbytes-1-j) +: 8];
                end
            end
        end
        return res;
    endfunction

    assign emit_last = ({1'b0, emit_idx_q} == (seg_cnt_q - 3'd1));

    always_comb begin
        state_d       = state_q;
        s_axis_tready = 1'b0;
        phv_ready     = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tuser  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        emit_adv      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_axis_tready = !areset;
                if (s_axis_tvalid && !areset) begin
                    state_d = s_axis_tlast ? ST_WAIT_PHV : ST_HDR_COLLECT;
                end
            end
            ST_HDR_COLLECT: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && (s_axis_tlast || seg_cnt_q == 3'd3)) begin
                    state_d = ST_WAIT_PHV;
                end
            end
            ST_WAIT_PHV: begin
                phv_ready = 1'b1;
                if (phv_valid) begin
                    state_d = ST_RAM_RD;
                end
            end
            ST_RAM_RD: state_d = ST_APPLY;
            ST_APPLY:  state_d = ST_EMIT_HDR;
            ST_EMIT_HDR: begin
                m_axis_tvalid = !drop;
                m_axis_tdata  = hdr_q[emit_idx_q];
                m_axis_tkeep  = keep_q[emit_idx_q];
                m_axis_tlast  = last_q[emit_idx_q];
                m_axis_tuser  = (emit_idx_q == 2'd0) ? phv_q[C_S_AXIS_TUSER_WIDTH-1:0] : '0;
                emit_adv      = drop || m_axis_tready;
                if (emit_adv && emit_last) begin
                    state_d = last_q[emit_idx_q] ? ST_IDLE : ST_PASS_BODY;
                end
            end
            ST_PASS_BODY: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tkeep  = s_axis_tkeep;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tvalid = s_axis_tvalid && !drop;
                s_axis_tready = drop || m_axis_tready;
                if (s_axis_tvalid && s_axis_tready && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            state_q    <= ST_IDLE;
            hdr_q      <= '0;
            keep_q     <= '0;
            last_q     <= '0;
            seg_cnt_q  <= '0;
            emit_idx_q <= '0;
            phv_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (s_axis_tvalid) begin
                        hdr_q      <= '0;
                        keep_q     <= '0;
                        last_q     <= '0;
                        hdr_q[0]   <= s_axis_tdata;
                        keep_q[0]  <= s_axis_tkeep;
                        last_q[0]  <= s_axis_tlast;
                        seg_cnt_q  <= 3'd1;
                        emit_idx_q <= 2'd0;
                    end
                end
                ST_HDR_COLLECT: begin
                    if (s_axis_tvalid) begin
                        hdr_q[seg_cnt_q[1:0]]  <= s_axis_tdata;
                        keep_q[seg_cnt_q[1:0]] <= s_axis_tkeep;
                        last_q[seg_cnt_q[1:0]] <= s_axis_tlast;
                        seg_cnt_q              <= seg_cnt_q + 3'd1;
                    end
                end
                ST_WAIT_PHV: begin
                    if (phv_valid) begin
                        phv_q <= phv_in;
                    end
                end
                ST_APPLY: hdr_q <= apply_actions(hdr_q, act_rd_data, phv_q);
                ST_EMIT_HDR: begin
                    if (emit_adv) begin
                        emit_idx_q <= emit_idx_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_deparser.sv
// Scoreboard bench for deparser: expected beats are queued at stimulus time and popped on output handshakes.
module tb_deparser;

    logic           axis_clk = 1'b0;
    logic           areset = 1'b1;
    logic [255:0]   s_axis_tdata = '0;
    logic [127:0]   s_axis_tuser = '0;
    logic [31:0]    s_axis_tkeep = '0;
    logic           s_axis_tvalid = 1'b0;
    logic           s_axis_tlast = 1'b0;
    logic           s_axis_tready;
    logic [1123:0]  phv_in = '0;
    logic           phv_valid = 1'b0;
    logic           phv_ready;
    logic           act_wr_en = 1'b0;
    logic [3:0]     act_wr_addr = '0;
    logic [159:0]   act_wr_data = '0;
    logic [255:0]   m_axis_tdata;
    logic [127:0]   m_axis_tuser;
    logic [31:0]    m_axis_tkeep;
    logic           m_axis_tvalid;
    logic           m_axis_tlast;
    logic           m_axis_tready = 1'b1;

    deparser dut (
        .axis_clk      (axis_clk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .phv_in        (phv_in),
        .phv_valid     (phv_valid),
        .phv_ready     (phv_ready),
        .act_wr_en     (act_wr_en),
        .act_wr_addr   (act_wr_addr),
        .act_wr_data   (act_wr_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    typedef struct packed {
        logic [255:0] d;
        logic [127:0] u;
        logic [31:0]  k;
        logic         l;
    } beat_t;

    beat_t         exp_q[$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            phv_cyc = 0;
    bit            await_first = 1'b0;
    bit            tog_mode = 1'b0;
    logic [159:0]  ram_model [16];
    logic [7:0]    mb [128];
    logic [1123:0] phv;

    initial forever #5 axis_clk = ~axis_clk;
    initial forever begin @(posedge axis_clk); cyc++; end
    initial forever begin
        @(posedge axis_clk);
        #1;
        m_axis_tready = tog_mode ? ~m_axis_tready : 1'b1;
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: stall stability, first-beat latency and in-order scoreboard compare.
    beat_t        mon_e;
    bit           prev_stall = 1'b0;
    logic [255:0] pd;
    logic [127:0] pu;
    logic [31:0]  pk;
    logic         pl;
    initial forever begin
        @(negedge axis_clk);
        if (areset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 256'(m_axis_tvalid), 256'(1));
                chk("stall_tdata", m_axis_tdata, pd);
                chk("stall_tuser", 256'(m_axis_tuser), 256'(pu));
                chk("stall_tkeep", 256'(m_axis_tkeep), 256'(pk));
                chk("stall_tlast", 256'(m_axis_tlast), 256'(pl));
            end
            if (m_axis_tvalid && await_first) begin
                chk("first_valid_latency", 256'(cyc - phv_cyc), 256'(3));
                await_first = 1'b0;
            end
            if (m_axis_tvalid && exp_q.size() == 0) begin
                chk("spurious_valid", 256'(m_axis_tvalid), 256'(0));
            end else if (m_axis_tvalid && m_axis_tready) begin
                mon_e = exp_q.pop_front();
                chk("tdata", m_axis_tdata, mon_e.d);
                chk("tuser", 256'(m_axis_tuser), 256'(mon_e.u));
                chk("tkeep", 256'(m_axis_tkeep), 256'(mon_e.k));
                chk("tlast", 256'(m_axis_tlast), 256'(mon_e.l));
                $display("beat tlast=%0b tkeep=%h tdata=%h", m_axis_tlast, m_axis_tkeep, m_axis_tdata);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            pd = m_axis_tdata; pu = m_axis_tuser; pk = m_axis_tkeep; pl = m_axis_tlast;
        end
    end

    task automatic write_entry(input logic [3:0] addr, input logic [159:0] data);
        act_wr_addr = addr;
        act_wr_data = data;
        act_wr_en   = 1'b1;
        @(posedge axis_clk);
        #1;
        act_wr_en = 1'b0;
        ram_model[addr] = data;
    endtask

    task automatic model_apply(input logic [159:0] ent, input logic [1123:0] p);
        logic [15:0] a;
        int n, base, off, idx;
        for (int i = 0; i < 10; i++) begin
            a   = ent[159-16*i -: 16];
            idx = int'(a[5:3]);
            off = int'(a[12:6]);
            n   = 0;
            base = 0;
            if (a[0]) begin
                case (a[2:1])
                    2'b01: begin n = 2; base = 356 + 16*idx; end
                    2'b10: begin n = 4; base = 484 + 32*idx; end
                    2'b11: begin n = 6; base = 740 + 48*idx; end
                    default: n = 0;
                endcase
            end
            for (int j = 0; j < n; j++) begin
                if (off + j < 128) mb[off+j] = p[base + 8*(n-1-j) +: 8];
            end
        end
    endtask

    task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic l);
        int n = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = {4{$urandom()}};
        s_axis_tvalid = 1'b1;
        do begin @(negedge axis_clk); n++; end while (!s_axis_tready && n < 500);
        if (!s_axis_tready) chk("s_ready_timeout", 256'(s_axis_tready), 256'(1));
        @(posedge axis_clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_phv(input bit expect_emit);
        int n = 0;
        phv_in    = phv;
        phv_valid = 1'b1;
        do begin @(negedge axis_clk); n++; end while (!phv_ready && n < 500);
        if (!phv_ready) chk("phv_ready_timeout", 256'(phv_ready), 256'(1));
        phv_cyc     = cyc;
        await_first = expect_emit;
        @(posedge axis_clk);
        #1;
        phv_valid = 1'b0;
    endtask

    task automatic rand_phv(input logic [11:0] vlan);
        for (int i = 0; i < 1124; i++) phv[i] = 1'($urandom_range(0, 1));
        phv[128]     = 1'b0;
        phv[140:129] = vlan;
    endtask

    task automatic run_pkt(input int nseg);
        logic [255:0] segs [8];
        logic [31:0]  lastk;
        beat_t        e;
        bit           drop_exp;
        int           nh, n;
`ifdef DEPARSER_DROP_EN
        drop_exp = phv[128];
`else
        drop_exp = 1'b0;
`endif
        lastk = 32'h00FF_FFFF;
        nh = (nseg < 4) ? nseg : 4;
        for (int s = 0; s < nseg; s++) segs[s] = {8{$urandom()}};
        for (int b = 0; b < 128; b++) mb[b] = (b/32 < nh) ? segs[b/32][8*(b%32) +: 8] : 8'h00;
        model_apply(ram_model[phv[136:133]], phv);
        if (!drop_exp) begin
            for (int s = 0; s < nseg; s++) begin
                if (s < 4) begin
                    for (int b = 0; b < 32; b++) e.d[8*b +: 8] = mb[32*s+b];
                end else begin
                    e.d = segs[s];
                end
                e.u = (s == 0) ? phv[127:0] : '0;
                e.k = (s == nseg-1) ? lastk : '1;
                e.l = (s == nseg-1);
                exp_q.push_back(e);
            end
        end
        for (int s = 0; s < nh; s++) send_beat(segs[s], (s == nseg-1) ? lastk : '1, s == nseg-1);
        send_phv(!drop_exp);
        for (int s = nh; s < nseg; s++) send_beat(segs[s], (s == nseg-1) ? lastk : '1, s == nseg-1);
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin @(negedge axis_clk); n++; end
        chk("drain", 256'(exp_q.size()), 256'(0));
        repeat (20) @(negedge axis_clk);
        chk("idle_ready", 256'(s_axis_tready), 256'(1));
        exp_q.delete();
        await_first = 1'b0;
        @(posedge axis_clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram_model[i] = '0;
        repeat (3) @(negedge axis_clk);
        chk("rst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
        chk("rst_m_tlast", 256'(m_axis_tlast), 256'(0));
        chk("rst_m_tdata", m_axis_tdata, 256'(0));
        chk("rst_m_tuser", 256'(m_axis_tuser), 256'(0));
        chk("rst_m_tkeep", 256'(m_axis_tkeep), 256'(0));
        chk("rst_s_tready", 256'(s_axis_tready), 256'(0));
        chk("rst_phv_ready", 256'(phv_ready), 256'(0));
        areset = 1'b0;
        @(negedge axis_clk);
        chk("idle_s_tready", 256'(s_axis_tready), 256'(1));
        chk("idle_phv_ready", 256'(phv_ready), 256'(0));

        // A PHV offered with no packet buffered must be held off.
        phv_valid = 1'b1;
        repeat (3) begin
            @(negedge axis_clk);
            chk("early_phv_ready", 256'(phv_ready), 256'(0));
        end
        phv_valid = 1'b0;
        @(posedge axis_clk);
        #1;

        write_entry(4'd1, {16'h0303, 144'b0});
        rand_phv(12'h010);
        phv[356 +: 16] = 16'h86DD;
        run_pkt(2);

        write_entry(4'd2, {16'h000F, 144'b0});
        rand_phv(12'h020);
        phv[788 +: 48] = 48'h0A0B0C0D0E0F;
        run_pkt(3);

        write_entry(4'd3, {16'h1F95, 144'b0});
        rand_phv(12'h030);
        phv[548 +: 32] = 32'h11223344;
        run_pkt(4);

        write_entry(4'd4, {16'h0303, 16'h000F, 112'b0, 16'h0F3F});
        rand_phv(12'h045);
        tog_mode = 1'b1;
        run_pkt(6);
        tog_mode = 1'b0;

        write_entry(4'd5, {16'h0503, 16'h050B, 128'b0});
        rand_phv(12'h050);
        run_pkt(1);

        rand_phv(12'h0F3);
        run_pkt(5);

        rand_phv(12'h010);
        phv[128] = 1'b1;
        run_pkt(6);
        rand_phv(12'h010);
        run_pkt(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/deparser.md
# deparser

Rebuilds outgoing packet headers from the PHV at the end of the RMT pipeline, the inverse of the parser. Buffers the first four 256-bit segments (128 B) of each packet and waits for that packet's PHV. Applies up to 10 deparse actions, selected per VLAN, that write PHV containers back into header bytes. Emits the packet on an AXI-Stream master with full backpressure; body segments beyond 128 B pass through unchanged.

## Interface
- C_S_AXIS_DATA_WIDTH, 256, stream data width
- C_S_AXIS_TUSER_WIDTH, 128, stream tuser width
- PKT_HDR_LEN, 1124, PHV width
- axis_clk  in  1  clock
- areset  in  1  reset; one clock, asynchronous, active-high
- s_axis_tdata/tuser/tkeep/tvalid/tlast  in  256/128/32/1/1  packet input
- s_axis_tready  out  1  input ready
- phv_in  in  1124  PHV from last stage
- phv_valid  in  1  PHV valid
- phv_ready  out  1  PHV accepted when phv_valid&&phv_ready
- act_wr_en  in  1  action RAM write strobe
- act_wr_addr  in  4  action RAM entry
- act_wr_data  in  160  10 actions; action i at [160-16(i+1)+:16], matching the parser's ordering
- m_axis_tdata/tuser/tkeep/tvalid/tlast  out  256/128/32/1/1  packet output
- m_axis_tready  in  1  output ready

## Operation
- PHV map:
  - 6B[i] at 740+48i.
  - 4B[i] at 484+32i.
  - 2B[i] at 356+16i.
  - vlan_id at [140:129].
  - bit 128 reserved/drop.
  - tuser at [127:0].
- Action word:
  - [0] valid.
  - [2:1] type: 01=2B, 10=4B, 11=6B, 00=skip.
  - [5:3] container index.
  - [12:6] byte offset 0..127.
  - [15:13] reserved.
- Packet byte k of the header window maps to buffer[8k+:8]; segment n holds bytes 32n..32n+31.
- Container written big-endian: the MS byte goes to the offset byte.
- Bytes past 127 are discarded.
- Actions apply in index order 0..9; on overlap, the higher index wins.
- Skipped actions: valid=0 or type=00.
- States:
  - IDLE: s_axis_tready=1. On a beat, store it as segment 0, clear the other segments, go to HDR_COLLECT (or WAIT_PHV if tlast).
  - HDR_COLLECT: store beats into segments 1..3. Go to WAIT_PHV on tlast or after segment 3 is stored.
  - WAIT_PHV: s_axis_tready=0, phv_ready=1. On handshake, latch the PHV and present vlan_id[7:4] to the RAM; go to RAM_RD.
  - RAM_RD: RAM output becomes valid; go to APPLY.
  - APPLY: write all 10 actions into the buffer; go to EMIT_HDR.
  - EMIT_HDR: drive buffered segments in order, each with its stored tkeep/tlast. After the last stored segment, go to IDLE if it had tlast, else PASS_BODY.
  - PASS_BODY: combinational pass-through; m_axis_tvalid=s_axis_tvalid and s_axis_tready=m_axis_tready. Go to IDLE on the tlast handshake.
- m_axis_tuser = latched PHV[127:0] on the first beat, 0 on later beats.
- Action RAM writes take effect the cycle after act_wr_en. A write to the entry being read in RAM_RD returns the old data.

## Timing
- Reset values:
  - State IDLE.
  - m_axis_tvalid/tlast/tdata/tuser/tkeep = 0.
  - s_axis_tready = 0 while areset is high, 1 in IDLE after reset.
  - phv_ready = 0.
  - RAM contents = 0 (all actions skip).
- First m_axis_tvalid comes 3 cycles after the PHV handshake (RAM_RD, APPLY, then EMIT_HDR).
- AXIS rule: while tvalid&&!tready, tdata/tkeep/tlast/tuser stay stable. A buffered segment advances only on m_axis handshake.
- One beat per cycle in EMIT_HDR under a continuous m_axis_tready.
- areset mid-packet: the partial packet and latched PHV are lost. Upstream resets together.
- A PHV arriving before the packet is held off by phv_ready=0.

## Configuration
- DEPARSER_DROP_EN defined:
  - PHV bit 128 = drop.
  - If set, all segments are consumed with m_axis_tvalid held 0, and PASS_BODY sinks the body with s_axis_tready=1.
- Undefined: bit 128 is ignored and every packet is emitted.

## Structure
- Package deparser_pkg holds:
  - Container base offsets (740/484/356).
  - Action field positions.
  - Type codes.
  - VLAN/tuser/drop bit positions.
  - State enum.
  - Header segment count (4).
- Sub-module deparse_act_ram: 16x160 simple dual-port RAM, 1-cycle registered read, write-first disabled.

## Test plan
- 2-segment packet, vlan_id=0x010, entry 1 action0=0x0303, 2B[0]=16'h86DD, rest skip -> tdata[96+:8]=0x86, [104+:8]=0xDD; remaining bytes, tkeep and tlast unchanged; first valid 3 cycles after the PHV handshake.
- Action0=0x000F, 6B[1]=48'h0A0B0C0D0E0F -> bytes 0..5 = 0A 0B 0C 0D 0E 0F.
- Action0=0x1F95, 4B[2]=32'h11223344 -> byte126=0x11, byte127=0x22; 0x33/0x44 dropped; no other byte changed.
- 6-segment packet with m_axis_tready toggling 1010... -> segments 0..3 modified, 4..5 bit-identical, data stable during stalls, tlast only on beat 5.
- Actions 0 and 1 both write offset 20 -> action 1's value appears; entry all-zero -> packet unmodified.
- With DEPARSER_DROP_EN and PHV bit128=1 -> no m_axis_tvalid for the packet; the next packet is emitted normally.
